// File: rtl/rv32i_types.sv
// RV32I shared types: opcode enum, encoder format enum, instruction field bundle.
package rv32i_types;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        fmt_r, fmt_i, fmt_s, fmt_b, fmt_u, fmt_j
    } rv32i_format_e;

    // Opcode is plain bits so that unknown encodings can be presented.
    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
    } instruction_fields_t;

    // True when v is representable as a signed value of the given bit count.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic signed [31:0] s;
        s = $signed(v) >>> (bits - 1);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// Output buffer for encoded words; registered valid/ready flags, no fall-through.
import rv32i_types::*;

module instr_enc_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             push;
    logic             pop;

    assign push      = push_valid && push_ready;
    assign pop       = pop_valid && pop_ready;
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign pop_data  = mem[rd_ptr];

    // Flags are registered from next count so ready never depends on pop_ready combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            push_ready <= 1'b0;
            pop_valid  <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count      <= count_nxt;
            push_ready <= (count_nxt != CW'(DEPTH));
            pop_valid  <= (count_nxt != '0);
        end
    end

endmodule

// File: rtl/instruction_encoder.sv
// Packs RV32I fields into a 32-bit word and buffers it in a small FIFO.
// Define INSTR_ENC_RANGE_CHECK_EN to flag immediates the format cannot hold.
import rv32i_types::*;

module instruction_encoder #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  instruction_fields_t in_fields,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_inst,
    output logic                out_err
);

    localparam int unsigned ENC_W = 33;

    function automatic logic [ENC_W-1:0] encode(input instruction_fields_t f);
        rv32i_format_e fmt;
        logic          known;
        logic          shift;
        logic          err;
        logic [31:0]   imm;
        logic [31:0]   inst;
        imm   = f.imm;
        fmt   = fmt_i;
        known = 1'b1;
        err   = 1'b0;
        inst  = NOP_INST;
        case (f.opcode)
            op_reg:                          fmt = fmt_r;
            op_load, op_imm, op_jalr, op_csr: fmt = fmt_i;
            op_store:                        fmt = fmt_s;
            op_br:                           fmt = fmt_b;
            op_lui, op_auipc:                fmt = fmt_u;
            op_jal:                          fmt = fmt_j;
            default:                         known = 1'b0;
        endcase
        shift = (f.opcode == op_imm) && ((f.funct3 == 3'b001) || (f.funct3 == 3'b101));
        case (fmt)
            fmt_r: inst = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
            fmt_i: inst = shift ? {f.funct7, imm[4:0], f.rs1, f.funct3, f.rd, f.opcode}
                                : {imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
            fmt_s: inst = {imm[11:5], f.rs2, f.rs1, f.funct3, imm[4:0], f.opcode};
            fmt_b: inst = {imm[12], imm[10:5], f.rs2, f.rs1, f.funct3, imm[4:1], imm[11], f.opcode};
            fmt_u: inst = {imm[31:12], f.rd, f.opcode};
            fmt_j: inst = {imm[20], imm[10:1], imm[11], imm[19:12], f.rd, f.opcode};
            default: inst = NOP_INST;
        endcase
        if (!known) inst = NOP_INST;
`ifdef INSTR_ENC_RANGE_CHECK_EN
        // The word is still emitted truncated; err only marks it.
        if (!known) begin
            err = 1'b1;
        end else begin
            case (fmt)
                fmt_i:   err = shift ? (imm[31:5] != '0) : !fits_signed(imm, 12);
                fmt_s:   err = !fits_signed(imm, 12);
                fmt_b:   err = !fits_signed(imm, 13) || imm[0];
                fmt_u:   err = (imm[11:0] != '0);
                fmt_j:   err = !fits_signed(imm, 21) || imm[0];
                default: err = 1'b0;
            endcase
        end
`else
        err = 1'b0;
`endif
        return {err, inst};
    endfunction

    logic [ENC_W-1:0] enc_c;
    logic [ENC_W-1:0] head;

    assign enc_c = encode(in_fields);
    assign {out_err, out_inst} = head;

    instr_enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENC_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  (enc_c),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (head)
    );

endmodule
